morse_msg_sched: RTL and testbench
==================================

MORSE_MSG_SCHED -- requirements
Module: morse_msg_sched

Interface
REQ-001 SHALL have port Clock  in  1  system clock; every flop is updated on its rising edge.
REQ-002 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port tick  in  1  one-Clock-wide timing pulse (half-second unit); all durations are counted in ticks.
REQ-004 SHALL have port wr_en  in  1  enqueue request for wr_letter.
REQ-005 SHALL have port wr_letter  in  3  letter select (0=A .. 7=H).
REQ-006 SHALL have port start  in  1  begin transmitting the queued message; sampled only in IDLE.
REQ-007 SHALL have port full  out  1  high when the FIFO holds 4 entries.
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port led  out  1  Morse output; high only in state ON.
REQ-010 SHALL have port done  out  1  single-Clock pulse when the message completes.
REQ-011 SHALL have port ovf  out  1  sticky flag: a write was attempted while full.

Function
REQ-012 SHALL buffer letters in a 4-entry FIFO with 2-bit wrapping pointers and a 3-bit count.
- A write with wr_en=1 and full=0 enqueues.
- A write while full is dropped and sets ovf.
- A simultaneous write and dequeue leaves the count unchanged.
REQ-013 SHALL map letters as fixed {len, pattern}, symbol i at pattern[i], transmitted i=0 first, 1=dash:
- A=2,'b0010 B=4,'b0001 C=4,'b0101 D=3,'b0001
- E=1,'b0000 F=4,'b0100 G=3,'b0011 H=4,'b0000
REQ-014 SHALL implement the states IDLE, LOAD, ON, GAP, LGAP, FIN.
REQ-015 IDLE: start=1 and count>0 -> LOAD; start=1 and count=0 is ignored.
REQ-016 LOAD (exactly one Clock, independent of tick):
- Dequeue the head entry.
- Latch its pattern into a 4-bit shift register and its len into a symbol counter.
- Load the tick counter with 1 for a dot or 3 for a dash.
- Go to ON.
REQ-017 ON: each tick decrements the tick counter; on the tick where it reaches 0, decrement the symbol counter and shift the pattern right.
- Symbols remain -> GAP with tick counter=1.
- No symbols remain -> LGAP with tick counter=3.
REQ-018 GAP: on the tick where the counter reaches 0, reload it per the next symbol (1 dot, 3 dash) and go to ON.
REQ-019 LGAP: on the tick where the counter reaches 0:
- count>0 -> LOAD.
- Otherwise -> FIN.
REQ-020 FIN SHALL assert done for one Clock and go to IDLE.
REQ-021 Writes SHALL be accepted in every state; letters enqueued before LGAP expires are transmitted in the same message.
REQ-022 Counters SHALL change only on Clock edges where tick=1, except in LOAD; start while busy=1 is ignored.
REQ-023 All outputs SHALL be registered; led SHALL rise on the Clock edge that enters ON.

Reset
REQ-024 Reset=1 SHALL set: state IDLE, FIFO pointers and count 0, ovf 0, led/done/busy 0, all counters 0.
REQ-025 Reset SHALL take priority over every other input, including when asserted mid-letter.

Structure
REQ-026 SHALL place the letter table, the state encoding and the constants DOT_TICKS=1, DASH_TICKS=3, LGAP_TICKS=3, DEPTH=4 in the shared package morse_pkg.
REQ-027 SHALL instantiate the FIFO as one sub-module, morse_fifo4, containing storage, pointers, count, full and empty; sequencing stays in the parent.

Verification
REQ-028 Enqueue E, start, tick every 4 Clocks -> led high for 1 tick, low for 3 ticks, done pulses once, busy falls with done.
REQ-029 Enqueue A then B, start -> led in ticks:
- A: 1 on, 1 off, 3 on, then 3 off.
- B: 3 on, then 1 on, 1 on, 1 on, each symbol separated by 1 off.
- After B: 3 off, then done.
REQ-030 Enqueue 5 letters back-to-back -> full=1 after the 4th, 5th dropped, ovf=1, exactly 4 letters transmitted.
REQ-031 Start with empty FIFO -> busy stays 0, led stays 0, no done.
REQ-032 Enqueue H, start, enqueue G during H's 2nd symbol -> G follows H after a 3-tick gap with a single done at the end.
REQ-033 Assert Reset during the ON phase of a C dash -> next Clock: led=0, busy=0, full=0, ovf=0; a subsequent start is ignored until a new write.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse message scheduler.
// Holds the letter table (A..H), the sequencer state encoding and the
// timing constants, all counted in tick units.
package morse_pkg;

   localparam int DOT_TICKS  = 1;
   localparam int DASH_TICKS = 3;
   localparam int LGAP_TICKS = 3;
   localparam int DEPTH      = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ON   = 3'd2,
      ST_GAP  = 3'd3,
      ST_LGAP = 3'd4,
      ST_FIN  = 3'd5
   } state_t;

   // Symbol i lives in pattern[i] and is sent first-to-last from bit 0; 1 = dash.
   typedef struct packed {
      logic [2:0] len;
      logic [3:0] pattern;
   } letter_t;

   function automatic letter_t letter_lookup(input logic [2:0] code);
      letter_t l;
      case (code)
         3'd0:    l = '{len: 3'd2, pattern: 4'b0010};  // A .-
         3'd1:    l = '{len: 3'd4, pattern: 4'b0001};  // B -...
         3'd2:    l = '{len: 3'd4, pattern: 4'b0101};  // C -.-.
         3'd3:    l = '{len: 3'd3, pattern: 4'b0001};  // D -..
         3'd4:    l = '{len: 3'd1, pattern: 4'b0000};  // E .
         3'd5:    l = '{len: 3'd4, pattern: 4'b0100};  // F ..-.
         3'd6:    l = '{len: 3'd3, pattern: 4'b0011};  // G --.
         default: l = '{len: 3'd4, pattern: 4'b0000};  // H ....
      endcase
      return l;
   endfunction

   function automatic logic [1:0] symbol_ticks(input logic dash);
      return dash ? 2'(DASH_TICKS) : 2'(DOT_TICKS);
   endfunction

endpackage

// File: rtl/morse_fifo4.sv
// Four-entry letter FIFO.
// Ports: Clock/Reset (sync, active high), wr/wr_data enqueue request,
// rd dequeue strobe, rd_data head entry, full (registered), empty.
// A write while full is dropped; a read while empty is ignored.
module morse_fifo4
   import morse_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       wr,
   input  logic [2:0] wr_data,
   input  logic       rd,
   output logic [2:0] rd_data,
   output logic       full,
   output logic       empty
);

   logic [2:0] mem [DEPTH];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic [2:0] count_nxt;
   logic       wr_ok;
   logic       rd_ok;

   assign wr_ok   = wr && !full;
   assign rd_ok   = rd && !empty;
   assign empty   = (count == 3'd0);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_nxt = count + 3'd1;
         2'b01:   count_nxt = count - 3'd1;
         default: count_nxt = count;
      endcase
   end

   // full is kept as a flop so the top-level output stays registered.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 2'd1;
         if (rd_ok) rd_ptr <= rd_ptr + 2'd1;
         count <= count_nxt;
         full  <= (count_nxt == 3'(DEPTH));
      end
   end

   always_ff @(posedge Clock) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/morse_msg_sched.sv
// Morse message scheduler: queues letters A..H and keys them out on led.
// Ports: Clock, Reset (sync, active high), tick (time unit strobe),
// wr_en/wr_letter enqueue, start (honoured in IDLE only),
// full, busy, led, done (one-clock pulse), ovf (sticky write-while-full).
//
//   state | meaning
//   IDLE  | waiting for start with a non-empty queue
//   LOAD  | pop head letter, load pattern, symbol count, first symbol time
//   ON    | led keyed for the current symbol
//   GAP   | one-tick space between symbols of a letter
//   LGAP  | three-tick space after a letter; next letter or finish
//   FIN   | done pulse, then back to IDLE
module morse_msg_sched
   import morse_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       tick,
   input  logic       wr_en,
   input  logic [2:0] wr_letter,
   input  logic       start,
   output logic       full,
   output logic       busy,
   output logic       led,
   output logic       done,
   output logic       ovf
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] tick_cnt;
   logic [2:0] sym_cnt;
   logic [3:0] shreg;
   logic [2:0] head;
   logic       empty;
   logic       fifo_rd;
   logic       expire;
   letter_t    head_letter;
   logic       led_nxt;
   logic       busy_nxt;
   logic       done_nxt;
   logic       ovf_nxt;

   assign fifo_rd     = (state == ST_LOAD);
   assign head_letter = letter_lookup(head);
   // The tick that takes the tick counter from 1 to 0.
   assign expire      = tick && (tick_cnt == 2'd1);

   morse_fifo4 u_fifo (
      .Clock   (Clock),
      .Reset   (Reset),
      .wr      (wr_en),
      .wr_data (wr_letter),
      .rd      (fifo_rd),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= ST_IDLE;
         led   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         led   <= led_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         ovf   <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start && !empty) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_ON;
         ST_ON:   if (expire) state_nxt = (sym_cnt != 3'd1) ? ST_GAP : ST_LGAP;
         ST_GAP:  if (expire) state_nxt = ST_ON;
         ST_LGAP: if (expire) state_nxt = empty ? ST_FIN : ST_LOAD;
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode the next state so they change on the same edge as state.
   always_comb begin
      led_nxt  = (state_nxt == ST_ON);
      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_nxt == ST_FIN);
      ovf_nxt  = ovf || (wr_en && full);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tick_cnt <= '0;
         sym_cnt  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               shreg    <= head_letter.pattern;
               sym_cnt  <= head_letter.len;
               tick_cnt <= symbol_ticks(head_letter.pattern[0]);
            end
            ST_ON: if (tick) begin
               if (tick_cnt == 2'd1) begin
                  sym_cnt  <= sym_cnt - 3'd1;
                  shreg    <= shreg >> 1;
                  // Inter-symbol space is one dot long.
                  tick_cnt <= (sym_cnt != 3'd1) ? 2'(DOT_TICKS) : 2'(LGAP_TICKS);
               end else begin
                  tick_cnt <= tick_cnt - 2'd1;
               end
            end
            ST_GAP: if (tick) begin
               // shreg already holds the next symbol in bit 0.
               if (tick_cnt == 2'd1) tick_cnt <= symbol_ticks(shreg[0]);
               else                  tick_cnt <= tick_cnt - 2'd1;
            end
            ST_LGAP: if (tick) tick_cnt <= tick_cnt - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_msg_sched.sv
module tb_morse_msg_sched;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       tick;
   logic       wr_en;
   logic [2:0] wr_letter;
   logic       start;
   logic       full;
   logic       busy;
   logic       led;
   logic       done;
   logic       ovf;

   int    tests = 0;
   int    fails = 0;
   int    tick_n = 4;
   int    phase = 0;
   int    done_cnt = 0;
   bit    any_busy = 0;
   bit    any_led = 0;
   int    obs[$];
   int    exp_q[$];
   int    msg[$];
   string code [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

   always #5 Clock = ~Clock;

   morse_msg_sched dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .tick      (tick),
      .wr_en     (wr_en),
      .wr_letter (wr_letter),
      .start     (start),
      .full      (full),
      .busy      (busy),
      .led       (led),
      .done      (done),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input int got, input int want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // One clock: sample after the edge, then set tick for the next edge.
   // The led value held during a tick interval is recorded when that tick is armed.
   task automatic clk1();
      @(posedge Clock);
      #1;
      if (done) done_cnt++;
      if (busy) any_busy = 1;
      if (led)  any_led  = 1;
      phase = (phase + 1) % tick_n;
      tick  = (phase == 0);
      if (tick && busy && !Reset) obs.push_back(int'(led));
   endtask

   task automatic write_letter(input int l);
      wr_en     = 1'b1;
      wr_letter = 3'(l);
      clk1();
      wr_en     = 1'b0;
   endtask

   // Start on a tick edge so the following LOAD clock never coincides with a tick.
   task automatic do_start();
      int n = 0;
      while (!tick && n < 20) begin
         clk1();
         n++;
      end
      obs.delete();
      done_cnt = 0;
      start = 1'b1;
      clk1();
      start = 1'b0;
   endtask

   // Expected led level per tick, straight from the dot/dash strings.
   function automatic void build_exp();
      exp_q.delete();
      foreach (msg[i]) begin
         string s = code[msg[i]];
         for (int j = 0; j < s.len(); j++) begin
            int d = (s.substr(j, j) == "-") ? 3 : 1;
            repeat (d) exp_q.push_back(1);
            if (j != s.len() - 1) exp_q.push_back(0);
         end
         repeat (3) exp_q.push_back(0);
      end
   endfunction

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 2000) begin
         clk1();
         n++;
      end
      check({tag, "_idle"}, int'(busy), 0);
   endtask

   task automatic finish_msg(input string tag);
      int bad = -1;
      build_exp();
      wait_idle(tag);
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
         if (bad < 0 && obs[i] != exp_q[i]) bad = i;
      check({tag, "_len"}, obs.size(), exp_q.size());
      check({tag, "_first_bad_tick"}, bad, -1);
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_led_idle"}, int'(led), 0);
   endtask

   initial begin
      int n;
      Reset = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_letter = 3'd0; start = 1'b0;
      repeat (3) clk1();
      check("rst_full", int'(full), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_led",  int'(led),  0);
      check("rst_done", int'(done), 0);
      check("rst_ovf",  int'(ovf),  0);
      Reset = 1'b0;
      clk1();

      // Start with nothing queued
      any_busy = 0; any_led = 0;
      do_start();
      repeat (20) clk1();
      check("empty_busy", int'(any_busy), 0);
      check("empty_led",  int'(any_led),  0);
      check("empty_done", done_cnt, 0);

      // E, tick every 4 clocks
      tick_n = 4;
      msg = '{4};
      write_letter(4);
      do_start();
      check("e_busy_start", int'(busy), 1);
      finish_msg("e");
      check("e_done_low", int'(done), 0);

      // A then B
      tick_n = 3;
      msg = '{0, 1};
      write_letter(0);
      write_letter(1);
      do_start();
      finish_msg("ab");

      // Five writes back-to-back; the fifth is dropped
      tick_n = 2;
      msg.delete();
      for (int i = 0; i < 5; i++) begin
         int l = $urandom_range(0, 7);
         write_letter(l);
         if (i < 4) msg.push_back(l);
         if (i == 3) check("ovf_full_after4", int'(full), 1);
      end
      check("ovf_flag", int'(ovf), 1);
      do_start();
      finish_msg("ovf_msg");
      check("ovf_sticky", int'(ovf), 1);
      check("ovf_full_drained", int'(full), 0);

      // H, then G written during H's second symbol
      tick_n = 3;
      msg = '{7, 6};
      write_letter(7);
      do_start();
      n = 0;
      while (obs.size() < 2 && n < 200) begin
         clk1();
         n++;
      end
      clk1();
      check("hg_in_sym2", int'(led), 1);
      write_letter(6);
      finish_msg("hg");

      // Reset during the first dash of C with the queue refilled to full
      tick_n = 3;
      write_letter(2);
      write_letter(0);
      write_letter(1);
      write_letter(3);
      do_start();
      n = 0;
      while (!led && n < 50) begin
         clk1();
         n++;
      end
      clk1();
      write_letter(4);
      check("c_full_before_rst", int'(full), 1);
      check("c_led_before_rst", int'(led), 1);
      Reset = 1'b1;
      clk1();
      check("c_rst_led",  int'(led),  0);
      check("c_rst_busy", int'(busy), 0);
      check("c_rst_full", int'(full), 0);
      check("c_rst_ovf",  int'(ovf),  0);
      check("c_rst_done", int'(done), 0);
      Reset = 1'b0;
      clk1();
      any_busy = 0; any_led = 0;
      do_start();
      repeat (30) clk1();
      check("c_post_busy", int'(any_busy), 0);
      check("c_post_led",  int'(any_led),  0);
      check("c_post_done", done_cnt, 0);
      msg = '{5};
      write_letter(5);
      do_start();
      finish_msg("c_post_msg");

      // Random messages at random tick rates
      for (int m = 0; m < 6; m++) begin
         tick_n = $urandom_range(2, 5);
         msg.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            int l = $urandom_range(0, 7);
            msg.push_back(l);
            write_letter(l);
         end
         do_start();
         finish_msg($sformatf("rand%0d", m));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
